// File: rtl/ddr4_rdwr_scheduler.sv
// DDR4 column command scheduler: arbitrates one read and one write requester,
// enforces tCCD and data-bus turnaround, and emits tagged read/write data windows.
module ddr4_rdwr_scheduler #(
  parameter int TCL   = 12,
  parameter int TCWL  = 10,
  parameter int TCCD  = 4,
  parameter int BURST = 4,
  parameter int ADDRW = 31,
  parameter int TAGW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rd_req,
  input  logic [ADDRW-1:0] rd_addr,
  input  logic [TAGW-1:0]  rd_tag,
  output logic             rd_grant,
  input  logic             wr_req,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [TAGW-1:0]  wr_tag,
  output logic             wr_grant,
  output logic             cmd_valid,
  output logic             cmd_is_wr,
  output logic [ADDRW-1:0] cmd_addr,
  output logic             rdata_window,
  output logic             wdata_window,
  output logic             win_first,
  output logic [TAGW-1:0]  win_tag
);

  localparam int DEPTH = TCL + BURST + 1;
  localparam int CW    = (TCCD > 1) ? $clog2(TCCD) : 1;

  // Entry k of the reservation vector describes the data bus k clocks from now.
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] dir_q;
  logic [DEPTH-1:0] first_q;
  logic [TAGW-1:0]  tag_q [DEPTH];
  logic [CW-1:0]    ccd_q;
  logic             prefer_wr_q;

  logic rd_ok;
  logic wr_ok;

  // Slots are checked one clock ahead because the issue lands after this cycle's shift.
  always_comb begin
    rd_ok = (ccd_q == '0);
    wr_ok = (ccd_q == '0);
    for (int k = 0; k < DEPTH; k++) begin
      if (k >= TCL + 1 && k <= TCL + BURST && busy_q[k])
        rd_ok = 1'b0;
      if ((k == TCL || k == TCL + BURST + 1) && busy_q[k] && dir_q[k])
        rd_ok = 1'b0;
      if (k >= TCWL + 1 && k <= TCWL + BURST && busy_q[k])
        wr_ok = 1'b0;
      if ((k == TCWL || k == TCWL + BURST + 1) && busy_q[k] && !dir_q[k])
        wr_ok = 1'b0;
    end
  end

  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (!reset) begin
      rd_grant = rd_req && rd_ok && (!(wr_req && wr_ok) || !prefer_wr_q);
      wr_grant = wr_req && wr_ok && !rd_grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ccd_q       <= '0;
      prefer_wr_q <= 1'b0;
    end else if (rd_grant || wr_grant) begin
      ccd_q       <= CW'(TCCD - 1);
      prefer_wr_q <= rd_grant;
    end else if (ccd_q != '0) begin
      ccd_q <= ccd_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      dir_q   <= '0;
      first_q <= '0;
      for (int k = 0; k < DEPTH; k++)
        tag_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        busy_q[k]  <= busy_q[k+1];
        dir_q[k]   <= dir_q[k+1];
        first_q[k] <= first_q[k+1];
        tag_q[k]   <= tag_q[k+1];
      end
      busy_q[DEPTH-1]  <= 1'b0;
      dir_q[DEPTH-1]   <= 1'b0;
      first_q[DEPTH-1] <= 1'b0;
      tag_q[DEPTH-1]   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (rd_grant && k >= TCL && k < TCL + BURST) begin
          busy_q[k]  <= 1'b1;
          dir_q[k]   <= 1'b0;
          first_q[k] <= (k == TCL);
          tag_q[k]   <= rd_tag;
        end else if (wr_grant && k >= TCWL && k < TCWL + BURST) begin
          busy_q[k]  <= 1'b1;
          dir_q[k]   <= 1'b1;
          first_q[k] <= (k == TCWL);
          tag_q[k]   <= wr_tag;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_is_wr <= 1'b0;
      cmd_addr  <= '0;
    end else begin
      cmd_valid <= rd_grant || wr_grant;
      cmd_is_wr <= wr_grant;
      cmd_addr  <= wr_grant ? wr_addr : (rd_grant ? rd_addr : '0);
    end
  end

  assign rdata_window = busy_q[0] && !dir_q[0];
  assign wdata_window = busy_q[0] && dir_q[0];
  assign win_first    = busy_q[0] && first_q[0];
  assign win_tag      = tag_q[0];

  // A bus collision or unknown handshake state means the datapath would capture garbage.
  a_no_x : assert property (@(posedge clock) disable iff (reset)
      !$isunknown({rd_req, wr_req, rd_grant, wr_grant, rdata_window, wdata_window, win_first}))
    else $fatal(1, "ddr4_rdwr_scheduler: X on request/grant/window signals");

  a_no_collision : assert property (@(posedge clock) !(rdata_window && wdata_window))
    else $fatal(1, "ddr4_rdwr_scheduler: read and write windows overlap");

endmodule

// File: tb/tb_ddr4_rdwr_scheduler.sv
// Randomized bench for ddr4_rdwr_scheduler against an absolute-time bus-occupancy model.
module tb_ddr4_rdwr_scheduler;
  localparam int TCL   = 12;
  localparam int TCWL  = 10;
  localparam int TCCD  = 4;
  localparam int BURST = 4;
  localparam int ADDRW = 31;
  localparam int TAGW  = 4;
  localparam int NCYC  = 2400;
  localparam int HORIZON = 4096;

  logic             clock = 1'b0;
  logic             reset;
  logic             rd_req, wr_req;
  logic [ADDRW-1:0] rd_addr, wr_addr;
  logic [TAGW-1:0]  rd_tag, wr_tag;
  logic             rd_grant, wr_grant;
  logic             cmd_valid, cmd_is_wr;
  logic [ADDRW-1:0] cmd_addr;
  logic             rdata_window, wdata_window, win_first;
  logic [TAGW-1:0]  win_tag;

  int checks = 0;
  int errors = 0;

  // Model state: what the bus and command port should show at each absolute cycle.
  bit              bus_busy  [HORIZON];
  bit              bus_wr    [HORIZON];
  bit              bus_first [HORIZON];
  bit [TAGW-1:0]   bus_tag   [HORIZON];
  bit              exp_cmd   [HORIZON];
  bit              exp_cmdwr [HORIZON];
  bit [ADDRW-1:0]  exp_addr  [HORIZON];
  int              last_grant;
  bit              prefer_rd;
  bit              rd_pend, wr_pend;
  bit              exp_rg, exp_wg;

  ddr4_rdwr_scheduler #(
    .TCL(TCL), .TCWL(TCWL), .TCCD(TCCD), .BURST(BURST), .ADDRW(ADDRW), .TAGW(TAGW)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_grant(rd_grant),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_tag(wr_tag), .wr_grant(wr_grant),
    .cmd_valid(cmd_valid), .cmd_is_wr(cmd_is_wr), .cmd_addr(cmd_addr),
    .rdata_window(rdata_window), .wdata_window(wdata_window),
    .win_first(win_first), .win_tag(win_tag)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // A burst issued in cycle c commands at c+1 and uses bus cycles start..start+BURST-1.
  function automatic bit busFree(input int start, input bit is_wr);
    for (int i = 0; i < BURST; i++)
      if (bus_busy[start + i]) return 1'b0;
    if (bus_busy[start - 1] && bus_wr[start - 1] != is_wr) return 1'b0;
    if (bus_busy[start + BURST] && bus_wr[start + BURST] != is_wr) return 1'b0;
    return 1'b1;
  endfunction

  task automatic applyStimulus(input int cyc);
    int rate;
    rate = (((cyc / 300) % 3) == 0) ? 10 : ((((cyc / 300) % 3) == 1) ? 45 : 100);
    reset = (cyc < 3) || ($urandom_range(0, 499) == 0);
    if (!rd_pend && $urandom_range(0, 99) < rate) begin
      rd_pend = 1'b1;
      rd_addr = ADDRW'($urandom);
      rd_tag  = TAGW'($urandom);
    end else if (rd_pend && $urandom_range(0, 59) == 0) begin
      rd_pend = 1'b0;
    end
    if (!wr_pend && $urandom_range(0, 99) < rate) begin
      wr_pend = 1'b1;
      wr_addr = ADDRW'($urandom);
      wr_tag  = TAGW'($urandom);
    end else if (wr_pend && $urandom_range(0, 59) == 0) begin
      wr_pend = 1'b0;
    end
    rd_req = rd_pend;
    wr_req = wr_pend;
  endtask

  task automatic recordBurst(input int cyc, input bit is_wr, input bit [ADDRW-1:0] addr,
                             input bit [TAGW-1:0] tag);
    int start;
    start = cyc + 1 + (is_wr ? TCWL : TCL);
    exp_cmd[cyc + 1]   = 1'b1;
    exp_cmdwr[cyc + 1] = is_wr;
    exp_addr[cyc + 1]  = addr;
    for (int i = 0; i < BURST; i++) begin
      bus_busy[start + i]  = 1'b1;
      bus_wr[start + i]    = is_wr;
      bus_first[start + i] = (i == 0);
      bus_tag[start + i]   = tag;
    end
  endtask

  initial begin
    bit rd_elig, wr_elig;
    reset = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; rd_tag = '0; wr_tag = '0;
    rd_pend = 1'b0; wr_pend = 1'b0;
    last_grant = -1000;
    prefer_rd = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      checkOutput("cmd_valid", 64'(cmd_valid), 64'(exp_cmd[cyc]));
      if (exp_cmd[cyc]) begin
        checkOutput("cmd_is_wr", 64'(cmd_is_wr), 64'(exp_cmdwr[cyc]));
        checkOutput("cmd_addr", 64'(cmd_addr), 64'(exp_addr[cyc]));
      end
      checkOutput("rdata_window", 64'(rdata_window), 64'(bus_busy[cyc] && !bus_wr[cyc]));
      checkOutput("wdata_window", 64'(wdata_window), 64'(bus_busy[cyc] && bus_wr[cyc]));
      checkOutput("win_first", 64'(win_first), 64'(bus_first[cyc]));
      if (bus_busy[cyc])
        checkOutput("win_tag", 64'(win_tag), 64'(bus_tag[cyc]));

      applyStimulus(cyc);
      #1;
      exp_rg = 1'b0;
      exp_wg = 1'b0;
      if (!reset) begin
        rd_elig = rd_req && (cyc - last_grant >= TCCD) && busFree(cyc + 1 + TCL, 1'b0);
        wr_elig = wr_req && (cyc - last_grant >= TCCD) && busFree(cyc + 1 + TCWL, 1'b1);
        if (rd_elig && wr_elig) begin
          exp_rg = prefer_rd;
          exp_wg = !prefer_rd;
        end else begin
          exp_rg = rd_elig;
          exp_wg = wr_elig;
        end
      end
      checkOutput("rd_grant", 64'(rd_grant), 64'(exp_rg));
      checkOutput("wr_grant", 64'(wr_grant), 64'(exp_wg));

      if (reset) begin
        for (int i = cyc + 1; i < HORIZON; i++) begin
          bus_busy[i] = 1'b0;
          bus_first[i] = 1'b0;
        end
        last_grant = -1000;
        prefer_rd = 1'b1;
      end else if (exp_rg) begin
        recordBurst(cyc, 1'b0, rd_addr, rd_tag);
        last_grant = cyc;
        prefer_rd = 1'b0;
        rd_pend = 1'b0;
      end else if (exp_wg) begin
        recordBurst(cyc, 1'b1, wr_addr, wr_tag);
        last_grant = cyc;
        prefer_rd = 1'b1;
        wr_pend = 1'b0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
